// File: rtl/bra_jump_adder.sv
// rtl/bra_jump_adder.sv - fetch-stage next-PC generator (sequential / branch / jump)
//
// Selects the next instruction address from PC+4, a PC-relative branch
// target, or a region-relative jump target, and registers the result.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears Out
//   Op_code_in   [17] branch flag, [16] reserved, [15] jump flag, [14:0] immediate
//   bra_out_bit  branch condition from the compare unit (1 = taken)
//   Address      current PC
//   Out          registered next PC
module bra_jump_adder #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [17:0]       Op_code_in,
  input  logic              bra_out_bit,
  input  logic [ADDR_W-1:0] Address,
  output logic [ADDR_W-1:0] Out
);

  logic              w_jump;
  logic              w_branch;
  logic [OFF_W-1:0]  w_imm;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_boff;
  logic [ADDR_W-1:0] w_btgt;
  logic [ADDR_W-1:0] w_jtgt;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] r_out;

  assign w_jump   = Op_code_in[15];
  assign w_branch = Op_code_in[17];
  assign w_imm    = Op_code_in[OFF_W-1:0];

  assign w_seq  = Address + ADDR_W'(4);
  // Word offset: sign-extend the immediate, then scale to bytes.
  assign w_boff = {{(ADDR_W-OFF_W-2){w_imm[OFF_W-1]}}, w_imm, 2'b00};
  assign w_btgt = w_seq + w_boff;
  // Jump stays inside the 128 KiB region of the sequential address.
  assign w_jtgt = {w_seq[ADDR_W-1:OFF_W+2], w_imm, 2'b00};

  // The jump flag is tested first so bra_out_bit is never consulted for
  // jumps; an unknown condition bit cannot leak into the jump result.
  always_comb begin
    w_next = w_seq;
    if (w_jump) begin
      w_next = w_jtgt;
    end else if (w_branch) begin
      if (bra_out_bit) begin
        w_next = w_btgt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_next;
    end
  end

  assign Out = r_out;

endmodule

// File: tb/tb_bra_jump_adder.sv
// tb/tb_bra_jump_adder.sv - self-checking bench for bra_jump_adder
module tb_bra_jump_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] Op_code_in = '0;
  logic        bra_out_bit = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Out;

  int vectors = 0;
  int miscompares = 0;

  bra_jump_adder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Op_code_in  (Op_code_in),
    .bra_out_bit (bra_out_bit),
    .Address     (Address),
    .Out         (Out)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on byte addresses.
  function automatic logic [31:0] ref_next(input logic [31:0] addr,
                                           input logic [17:0] op,
                                           input logic        taken);
    longint two32 = 64'd4294967296;
    longint seq, imm, soff, res;
    seq  = (longint'(addr) + 4) % two32;
    imm  = longint'(op[14:0]);
    soff = (imm >= 16384) ? imm - 32768 : imm;
    if (op[15] == 1'b1)
      res = (seq / 131072) * 131072 + imm * 4;
    else if (op[17] == 1'b1 && taken == 1'b1)
      res = ((seq + soff * 4) % two32 + two32) % two32;
    else
      res = seq;
    return res[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    vectors++;
    assert (Out === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, Out, exp);
    end
  endtask

  // Drive inputs away from the edge, let one rising edge capture them.
  task automatic apply(input logic [31:0] a, input logic [17:0] op, input logic b);
    Address     = a;
    Op_code_in  = op;
    bra_out_bit = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [17:0] op;
    logic        b;

    // Reset held across several edges
    Address = 32'd5;
    #1;
    check("reset_initial", 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 32'h0);
    end
    #2;
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", 32'h0);
    @(posedge clk);
    #1;
    check("first_edge_seq", 32'd9);

    // Sequential and wrap
    apply(32'd5, 18'h0, 1'b0);
    check("seq_5", 32'd9);
    apply(32'hFFFF_FFFC, 18'h0, 1'b0);
    check("seq_wrap", 32'h0);
    apply(32'h200, 18'h10005, 1'b1);
    check("reserved_bit_ignored", 32'h204);

    // Branch positive offset
    apply(32'h100, {1'b1, 1'b0, 1'b0, 15'd3}, 1'b1);
    check("br_pos_taken", 32'h110);
    apply(32'h100, {1'b1, 1'b0, 1'b0, 15'd3}, 1'b0);
    check("br_pos_not_taken", 32'h104);

    // Branch negative offset
    apply(32'h100, {1'b1, 1'b0, 1'b0, 15'h7FFF}, 1'b1);
    check("br_neg_one", 32'h100);
    apply(32'h100, {1'b1, 1'b0, 1'b0, 15'h4000}, 1'b1);
    check("br_neg_wrap", 32'hFFFF_0104);

    // Jump priority, including unknown condition bit
    apply(32'h1234_5678, {1'b1, 1'b0, 1'b1, 15'h0010}, 1'b1);
    check("jump_priority", 32'h1234_0040);
    apply(32'h1234_5678, {1'b1, 1'b0, 1'b1, 15'h0010}, 1'bx);
    check("jump_cond_x", 32'h1234_0040);
    apply(32'h0001_0000, {1'b0, 1'b0, 1'b1, 15'h7FFF}, 1'b0);
    check("jump_max_imm", 32'h0001_FFFC);

    // Async reset mid-stream
    apply(32'h100, {1'b1, 1'b0, 1'b0, 15'd3}, 1'b1);
    check("pre_async_reset", 32'h110);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", 32'h0);
    @(posedge clk);
    #1;
    check("async_reset_hold", 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_release_no_edge", 32'h0);
    @(posedge clk);
    #1;
    check("after_async_release", ref_next(32'h100, {1'b1, 1'b0, 1'b0, 15'd3}, 1'b1));

    // Randomized vectors against the reference
    for (int i = 0; i < 300; i++) begin
      a  = $urandom;
      op = 18'($urandom);
      b  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
      apply(a, op, b);
      check("random", ref_next(a, op, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
